regfile_write_queue: RTL and testbench
======================================

Name: regfile_write_queue

Overview:
- Write-side companion to the 32x32 register file: merges ALU writeback and late load-return writes into the register file's single write port (we/wa/wd).
- Small in-order FIFO absorbs collisions between the two sources and drains one write per cycle.
- Optional lookup ports let the decode stage see pending writes that have not yet committed.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- CW, $clog2(DEPTH+1), width of the count output.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- alu_valid  input  1  ALU write request.
- alu_wa  input  5  ALU destination register.
- alu_wd  input  32  ALU write data.
- ld_valid  input  1  load-return write request.
- ld_wa  input  5  load destination register.
- ld_wd  input  32  load write data.
- in_ready  output  1  queue can accept a write from both sources this cycle.
- we  output  1  register file write enable.
- wa  output  5  register file write address.
- wd  output  32  register file write data.
- la1, la2  input  5 each  lookup addresses, driven from decode read addresses.
- lhit1, lhit2  output  1 each  a pending write targets la1 / la2.
- ld1, ld2  output  32 each  data of the youngest pending write to la1 / la2.
- count  output  CW  number of valid entries.
- empty  output  1  count == 0.

Behaviour:
- Reset (rst high at an edge):
  - Pointers, count and all entry valid state clear.
  - Next cycle: we=0, wa=0, wd=0, empty=1, count=0, lhit1=lhit2=0, ld1=ld2=0.
  - Entries in flight are discarded.
  - in_ready=0 during any cycle rst is high; inputs are ignored in that cycle.
- in_ready = !rst && (count <= DEPTH-2).
  - Guarantees two free slots, so both sources can push in the same cycle.
  - Producers hold valid/address/data until a cycle with in_ready=1.
- Accept:
  - A source's write is accepted at the edge where its valid && in_ready.
  - A write with wa == 0 is accepted but discarded: no entry, no count change.
- Ordering when both sources are accepted in one cycle:
  - The ld entry is enqueued first (older), then the alu entry.
  - Same-address collisions therefore commit alu_wd last.
- Drain:
  - we = !empty; wa/wd = head entry, combinational from FIFO state.
  - The register file always accepts, so the head pops at every edge where empty=0.
- Latency:
  - Write accepted at edge E into an empty queue appears on we/wa/wd in the cycle after E.
  - It commits to the register file at edge E+1.
  - Minimum accept-to-commit latency is 1 cycle.
- Count update:
  - Push (0, 1 or 2) and pop in the same edge are allowed.
  - count_next = count + pushes - pop.
  - Pointers wrap modulo DEPTH.
  - Overflow is impossible by construction. Underflow is impossible because pop requires !empty.
- Lookup (with the optional feature compiled in):
  - lhitN=1 iff laN != 0 and some valid entry, including the head currently being written, has wa == laN.
  - ldN = wd of the youngest such entry; ldN=0 when there is no hit.
  - Purely combinational.
  - Entries accepted at the current edge are not visible until after that edge.

Optional Feature:
- Macro: WQ_BYPASS_EN.
- Defined: lookup comparators and the youngest-match select are built, as described under Lookup.
- Undefined:
  - No comparators are built.
  - lhit1, lhit2, ld1 and ld2 are tied to 0.
  - Ports remain present.
  - All other behaviour is identical.

Test Plan:
- Reset: assert rst 2 cycles with alu_valid=1 -> during rst in_ready=0; after release count=0, empty=1, we=0, in_ready=1, and no write appears.
- Single write: alu wa=5, wd=0xDEADBEEF accepted at edge E -> next cycle we=1, wa=5, wd=0xDEADBEEF, count=1; following cycle we=0, count=0.
- Collision/order: at one edge, ld wa=3 wd=0x11 and alu wa=3 wd=0x22 -> commit order 0x11 then 0x22 on consecutive cycles. With WQ_BYPASS_EN, la1=3 while both pending -> lhit1=1, ld1=0x22; after the first pop -> ld1=0x22; after the second pop -> lhit1=0.
- Zero register: alu wa=0 wd=0xFFFFFFFF accepted -> count stays 0, we stays 0. la1=0 -> lhit1=0 in all cases.
- Backpressure, DEPTH=4, both sources valid every cycle:
  - count sequence 0,2,3; in_ready drops at count=3.
  - Queue drains to 2 and in_ready returns to 1.
  - Commit sequence exactly matches acceptance order, with no lost or duplicated writes.
- Mid-operation reset: count=3 with pending hits on la1 -> assert rst one edge -> next cycle count=0, we=0, lhit1=0. Discarded entries never reach we.

Source files
------------

// File: rtl/regfile_write_queue.sv
// Write queue merging ALU writeback and load-return writes into one register-file write port.
// Optional pending-write lookup is built when WQ_BYPASS_EN is defined.
module regfile_write_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_valid,
    input  logic [4:0]    alu_wa,
    input  logic [31:0]   alu_wd,
    input  logic          ld_valid,
    input  logic [4:0]    ld_wa,
    input  logic [31:0]   ld_wd,
    output logic          in_ready,
    output logic          we,
    output logic [4:0]    wa,
    output logic [31:0]   wd,
    input  logic [4:0]    la1,
    input  logic [4:0]    la2,
    output logic          lhit1,
    output logic          lhit2,
    output logic [31:0]   ld1,
    output logic [31:0]   ld2,
    output logic [CW-1:0] count,
    output logic          empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [4:0]    wa_q [DEPTH];
    logic [31:0]   wd_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          ld_push;
    logic          alu_push;
    logic          pop;
    logic [PW-1:0] alu_slot;

    // Two free slots are required so both sources can always push together.
    assign in_ready = !rst && (count_q <= CW'(DEPTH - 2));

    // Writes to r0 are accepted but never occupy a slot.
    assign ld_push  = ld_valid  && in_ready && (ld_wa  != 5'd0);
    assign alu_push = alu_valid && in_ready && (alu_wa != 5'd0);
    assign pop      = (count_q != '0);
    assign alu_slot = ld_push ? (wr_ptr_q + PW'(1)) : wr_ptr_q;

    always_comb begin
        count_d  = count_q + CW'(ld_push) + CW'(alu_push) - CW'(pop);
        wr_ptr_d = wr_ptr_q + PW'(ld_push) + PW'(alu_push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Load entry goes in first so a same-address ALU write commits last.
    always_ff @(posedge clk) begin
        if (ld_push) begin
            wa_q[wr_ptr_q] <= ld_wa;
            wd_q[wr_ptr_q] <= ld_wd;
        end
        if (alu_push) begin
            wa_q[alu_slot] <= alu_wa;
            wd_q[alu_slot] <= alu_wd;
        end
    end

    assign we    = pop;
    assign wa    = pop ? wa_q[rd_ptr_q] : 5'd0;
    assign wd    = pop ? wd_q[rd_ptr_q] : 32'd0;
    assign count = count_q;
    assign empty = (count_q == '0);

`ifdef WQ_BYPASS_EN
    // Scan oldest to youngest so the last match seen is the youngest.
    always_comb begin
        lhit1 = 1'b0;
        lhit2 = 1'b0;
        ld1   = 32'd0;
        ld2   = 32'd0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < count_q) begin
                if (la1 != 5'd0 && wa_q[rd_ptr_q + PW'(k)] == la1) begin
                    lhit1 = 1'b1;
                    ld1   = wd_q[rd_ptr_q + PW'(k)];
                end
                if (la2 != 5'd0 && wa_q[rd_ptr_q + PW'(k)] == la2) begin
                    lhit2 = 1'b1;
                    ld2   = wd_q[rd_ptr_q + PW'(k)];
                end
            end
        end
    end
`else
    logic unused_la;
    assign unused_la = ^{la1, la2};
    assign lhit1 = 1'b0;
    assign lhit2 = 1'b0;
    assign ld1   = 32'd0;
    assign ld2   = 32'd0;
`endif

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed bench for regfile_write_queue (DEPTH=4); lookup expectations follow WQ_BYPASS_EN.
module tb_regfile_write_queue;

`ifdef WQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, ld_valid;
    logic [4:0]  alu_wa, ld_wa, la1, la2;
    logic [31:0] alu_wd, ld_wd;
    logic        in_ready, we, lhit1, lhit2, empty;
    logic [4:0]  wa;
    logic [31:0] wd, ld1, ld2;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;
    logic [36:0] exp_q [$];
    int cnt_tab [6] = '{0, 2, 3, 2, 3, 2};
    int k;
    bit acc;

    regfile_write_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_wa(alu_wa), .alu_wd(alu_wd),
        .ld_valid(ld_valid), .ld_wa(ld_wa), .ld_wd(ld_wd),
        .in_ready(in_ready), .we(we), .wa(wa), .wd(wd),
        .la1(la1), .la2(la2), .lhit1(lhit1), .lhit2(lhit2),
        .ld1(ld1), .ld2(ld2), .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int n);
        ld_valid  = 1'b1;
        alu_valid = 1'b1;
        ld_wa     = 5'(10 + n);
        ld_wd     = 32'h1000_0000 + 32'(n);
        alu_wa    = 5'(20 + n);
        alu_wd    = 32'h2000_0000 + 32'(n);
    endtask

    initial begin
        rst = 1'b1;
        alu_valid = 1'b1; alu_wa = 5'd7; alu_wd = 32'h0BAD_0BAD;
        ld_valid = 1'b0; ld_wa = 5'd0; ld_wd = 32'd0;
        la1 = 5'd0; la2 = 5'd0;

        // reset held two cycles with a pending ALU request
        #1;
        chk("rst_in_ready_0", in_ready, 1'b0);
        step();
        chk("rst_in_ready_1", in_ready, 1'b0);
        step();
        rst = 1'b0;
        alu_valid = 1'b0;
        #1;
        chk("rst_count", count, 3'd0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_we", we, 1'b0);
        chk("rst_wa", wa, 5'd0);
        chk("rst_wd", wd, 32'd0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_lhit1", lhit1, 1'b0);
        chk("rst_ld1", ld1, 32'd0);
        step();
        chk("rst_no_write", we, 1'b0);

        // single ALU write
        alu_valid = 1'b1; alu_wa = 5'd5; alu_wd = 32'hDEAD_BEEF;
        step();
        alu_valid = 1'b0;
        #1;
        chk("single_we", we, 1'b1);
        chk("single_wa", wa, 5'd5);
        chk("single_wd", wd, 32'hDEAD_BEEF);
        chk("single_count", count, 3'd1);
        step();
        chk("single_we_off", we, 1'b0);
        chk("single_count_0", count, 3'd0);

        // same-address collision: load is older, ALU commits last
        ld_valid = 1'b1; ld_wa = 5'd3; ld_wd = 32'h11;
        alu_valid = 1'b1; alu_wa = 5'd3; alu_wd = 32'h22;
        step();
        ld_valid = 1'b0; alu_valid = 1'b0;
        la1 = 5'd3; la2 = 5'd4;
        #1;
        chk("coll_count", count, 3'd2);
        chk("coll_wa0", wa, 5'd3);
        chk("coll_wd0", wd, 32'h11);
        chk("coll_lhit1_a", lhit1, BYP);
        chk("coll_ld1_a", ld1, BYP ? 32'h22 : 32'h0);
        chk("coll_lhit2_a", lhit2, 1'b0);
        step();
        chk("coll_wd1", wd, 32'h22);
        chk("coll_count1", count, 3'd1);
        chk("coll_lhit1_b", lhit1, BYP);
        chk("coll_ld1_b", ld1, BYP ? 32'h22 : 32'h0);
        step();
        chk("coll_we_off", we, 1'b0);
        chk("coll_lhit1_c", lhit1, 1'b0);
        chk("coll_ld1_c", ld1, 32'h0);

        // writes to r0 are dropped
        alu_valid = 1'b1; alu_wa = 5'd0; alu_wd = 32'hFFFF_FFFF;
        la1 = 5'd0;
        step();
        alu_valid = 1'b0;
        #1;
        chk("zero_count", count, 3'd0);
        chk("zero_we", we, 1'b0);
        chk("zero_lhit1", lhit1, 1'b0);

        // backpressure: both sources valid every cycle
        k = 0;
        set_src(k);
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("bp_count_%0d", i), count, 32'(cnt_tab[i]));
            chk($sformatf("bp_in_ready_%0d", i), in_ready, 32'(cnt_tab[i] <= 2));
            chk($sformatf("bp_we_%0d", i), we, 32'(cnt_tab[i] != 0));
            if (cnt_tab[i] != 0) begin
                chk($sformatf("bp_wa_%0d", i), wa, 32'(exp_q[0][36:32]));
                chk($sformatf("bp_wd_%0d", i), wd, exp_q[0][31:0]);
            end
            acc = (cnt_tab[i] <= 2);
            step();
            if (cnt_tab[i] != 0) void'(exp_q.pop_front());
            if (acc) begin
                exp_q.push_back({ld_wa, ld_wd});
                exp_q.push_back({alu_wa, alu_wd});
                k++;
                set_src(k);
            end
        end
        ld_valid = 1'b0; alu_valid = 1'b0;
        #1;
        chk("bp_count_final", count, 3'd3);
        for (int j = 0; j < 10; j++) begin
            if (empty === 1'b1) break;
            chk($sformatf("drain_we_%0d", j), we, 1'b1);
            if (exp_q.size() == 0) begin
                chk($sformatf("drain_extra_%0d", j), wd, 32'hxxxx_xxxx);
            end else begin
                chk($sformatf("drain_wa_%0d", j), wa, 32'(exp_q[0][36:32]));
                chk($sformatf("drain_wd_%0d", j), wd, exp_q[0][31:0]);
                void'(exp_q.pop_front());
            end
            step();
        end
        chk("drain_left", exp_q.size(), 0);
        chk("drain_empty", empty, 1'b1);

        // mid-operation reset with pending hits
        ld_valid = 1'b1; ld_wa = 5'd9; ld_wd = 32'hA;
        alu_valid = 1'b1; alu_wa = 5'd9; alu_wd = 32'hB;
        step();
        ld_wd = 32'hC; alu_wd = 32'hD;
        step();
        ld_valid = 1'b0; alu_valid = 1'b0;
        la1 = 5'd9; la2 = 5'd9;
        #1;
        chk("mid_count", count, 3'd3);
        chk("mid_lhit1", lhit1, BYP);
        chk("mid_ld1", ld1, BYP ? 32'hD : 32'h0);
        chk("mid_lhit2", lhit2, BYP);
        rst = 1'b1;
        alu_valid = 1'b1; alu_wa = 5'd12; alu_wd = 32'h77;
        #1;
        chk("mid_rst_in_ready", in_ready, 1'b0);
        step();
        rst = 1'b0;
        alu_valid = 1'b0;
        #1;
        chk("mid_after_count", count, 3'd0);
        chk("mid_after_we", we, 1'b0);
        chk("mid_after_lhit1", lhit1, 1'b0);
        chk("mid_after_ld1", ld1, 32'h0);
        chk("mid_after_empty", empty, 1'b1);
        for (int j = 0; j < 3; j++) begin
            step();
            chk($sformatf("mid_no_write_%0d", j), we, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
